// File: rtl/countdown_pkg.sv
// rtl/countdown_pkg.sv - shared types for the countdown timer
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } countdown_state_t;

endpackage

// File: rtl/downcount_core.sv
// rtl/downcount_core.sv - loadable down-counter register with zero/one flags
module downcount_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_o,
  output logic             zero_o,
  output logic             one_o
);

  localparam logic [WIDTH-1:0] COUNT_ZERO = '0;
  localparam logic [WIDTH-1:0] COUNT_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] count_d, count_q;

  // Next count: clear beats load beats decrement; otherwise hold.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = COUNT_ZERO;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i) begin
      count_d = count_q - COUNT_ONE;
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= COUNT_ZERO;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == COUNT_ZERO);
  assign one_o   = (count_q == COUNT_ONE);

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - start/busy/done down-counter; COUNTDOWN_AUTORELOAD_EN enables periodic reload
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  countdown_state_t state_d, state_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;
  logic             core_load, core_dec, core_clr;
  logic [WIDTH-1:0] core_load_val;
  logic             cnt_zero, cnt_one;

`ifdef COUNTDOWN_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_d, reload_q;
  logic             reload_sel;
`endif

  // FSM next state and datapath controls; abort always wins.
  always_comb begin
    state_d   = state_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    core_load = 1'b0;
    core_dec  = 1'b0;
    core_clr  = 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
    reload_d   = reload_q;
    reload_sel = 1'b0;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (abort) begin
          core_clr = 1'b0;
          core_clr = 1'b1;
        end else if (start) begin
          core_load = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
          reload_d = load_val;
`endif
          if (load_val == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d  = IDLE;
          core_clr = 1'b1;
        end else if (en && (cnt_one || cnt_zero)) begin
          // Final enabled cycle of the window.
          done_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
          if (reload_q != '0) begin
            core_load  = 1'b1;
            reload_sel = 1'b1;
            busy_d     = 1'b1;
          end else begin
            core_clr = 1'b1;
            state_d  = DONE;
          end
`else
          core_clr = 1'b1;
          state_d  = DONE;
`endif
        end else begin
          core_dec = en;
          busy_d   = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        core_clr = 1'b1;
      end
    endcase
  end

`ifdef COUNTDOWN_AUTORELOAD_EN
  assign core_load_val = reload_sel ? reload_q : load_val;

  // Reload value captured on every accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end
`else
  assign core_load_val = load_val;
`endif

  // State and registered busy/done outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  downcount_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .load_i    (core_load),
    .dec_i     (core_dec),
    .clr_i     (core_clr),
    .load_val_i(core_load_val),
    .count_o   (count),
    .zero_o    (cnt_zero),
    .one_o     (cnt_one)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule
